// File: rtl/clct_gem_slope_corr_lut_pkg.sv
// Shared constants and helpers for the GEM-CSC slope corrector: key bounds,
// LUT address packing {region, parity, layer, bend} and slot indexing.
package clct_gem_slope_corr_lut_pkg;

  localparam int unsigned DefNClct    = 2;
  localparam int unsigned DefNLayer   = 2;
  localparam int unsigned DefMxLayB   = 1;
  localparam int unsigned DefMxBendB  = 4;
  localparam int unsigned DefMxKeyB   = 10;
  localparam int unsigned DefMxOffB   = 8;

  localparam int unsigned MinKeyHsMe1b = 0;
  localparam int unsigned MaxKeyHsMe1b = 511;
  localparam int unsigned MinKeyHsMe1a = 512;
  localparam int unsigned MaxKeyHsMe1a = 895;

  function automatic int unsigned slotIdx(input int unsigned c, input int unsigned l,
                                          input int unsigned nLayer);
    return c * nLayer + l;
  endfunction

  function automatic int unsigned packLutAdr(input bit me1a, input bit even,
                                             input int unsigned layer, input int unsigned bend,
                                             input int unsigned mxLayB,
                                             input int unsigned mxBendB);
    int unsigned adr;
    adr = (32'(me1a) << (mxLayB + mxBendB + 1)) | (32'(even) << (mxLayB + mxBendB)) |
          (layer << mxBendB) | bend;
    return adr;
  endfunction

endpackage

// File: rtl/clct_gem_slope_corr_lut_if.sv
// CLCT input bundle and corrected-key result bundle of the slope corrector.
interface clct_gem_slope_corr_lut_if #(
  parameter int unsigned NCLCT   = 2,
  parameter int unsigned NLAYER  = 2,
  parameter int unsigned MXBENDB = 4,
  parameter int unsigned MXKEYB  = 10,
  parameter int unsigned MXOFFB  = 8
);
  logic                             valid_in;
  logic [NCLCT*MXKEYB-1:0]          clct_xky;
  logic [NCLCT*MXBENDB-1:0]         clct_bend;
  logic [NCLCT-1:0]                 clct_lr;
  logic [NCLCT-1:0]                 is_me1a;
  logic                             even;
  logic                             clamp_en;

  logic                             valid_out;
  logic [NCLCT*NLAYER*MXKEYB-1:0]   xky_corr;
  logic [NCLCT*NLAYER-1:0]          outedge_lo;
  logic [NCLCT*NLAYER-1:0]          outedge_hi;
  logic [NCLCT*NLAYER*MXOFFB-1:0]   edgeoffset;

  modport master (
    output valid_in, clct_xky, clct_bend, clct_lr, is_me1a, even, clamp_en,
    input  valid_out, xky_corr, outedge_lo, outedge_hi, edgeoffset
  );

  modport slave (
    input  valid_in, clct_xky, clct_bend, clct_lr, is_me1a, even, clamp_en,
    output valid_out, xky_corr, outedge_lo, outedge_hi, edgeoffset
  );
endinterface

// File: rtl/clct_gem_slope_corr_slot.sv
// Stage-2 arithmetic for one (CLCT, layer) pair: apply offset, clamp to the
// region bounds and report how far beyond the bound the raw result fell.
module clct_gem_slope_corr_slot #(
  parameter int unsigned MXKEYB       = 10,
  parameter int unsigned MXOFFB       = 8,
  parameter int unsigned MINKEYHSME1B = 0,
  parameter int unsigned MAXKEYHSME1B = 511,
  parameter int unsigned MINKEYHSME1A = 512,
  parameter int unsigned MAXKEYHSME1A = 895
) (
  input  logic [MXKEYB-1:0] xky,
  input  logic [MXOFFB-1:0] off,
  input  logic              lr,
  input  logic              me1a,
  input  logic              clampEn,
  output logic [MXKEYB-1:0] key,
  output logic              edgeLo,
  output logic              edgeHi,
  output logic [MXOFFB-1:0] edgeOff
);
  localparam int unsigned W = MXKEYB + 2;
  localparam logic [W-1:0] KeyMax = W'((1 << MXKEYB) - 1);
  localparam logic [W-1:0] OffSat = W'((1 << MXOFFB) - 1);

  logic [W-1:0] lo, hi, x, o, loOff, sum, diff;

  always_comb begin
    lo      = clampEn ? (me1a ? W'(MINKEYHSME1A) : W'(MINKEYHSME1B)) : '0;
    hi      = clampEn ? (me1a ? W'(MAXKEYHSME1A) : W'(MAXKEYHSME1B)) : KeyMax;
    x       = W'(xky);
    o       = W'(off);
    loOff   = lo + o;
    sum     = x + o;
    diff    = '0;
    edgeLo  = 1'b0;
    edgeHi  = 1'b0;
    key     = '0;
    if (lr) begin
      if (x < loOff) begin
        key    = MXKEYB'(lo);
        edgeLo = 1'b1;
        diff   = loOff - x;
      end else begin
        key = MXKEYB'(x - o);
      end
    end else begin
      if (sum > hi) begin
        key    = MXKEYB'(hi);
        edgeHi = 1'b1;
        diff   = sum - hi;
      end else begin
        key = MXKEYB'(sum);
      end
    end
    edgeOff = (diff > OffSat) ? MXOFFB'(OffSat) : MXOFFB'(diff);
  end

endmodule

// File: rtl/clct_gem_slope_corr_lut.sv
// Two-stage GEM-CSC slope corrector with a run-time writable, bend-indexed
// offset LUT; extrapolates every CLCT key to every GEM layer.
module clct_gem_slope_corr_lut
  import clct_gem_slope_corr_lut_pkg::*;
#(
  parameter int unsigned NCLCT        = DefNClct,
  parameter int unsigned NLAYER       = DefNLayer,
  parameter int unsigned MXLAYB       = DefMxLayB,
  parameter int unsigned MXBENDB      = DefMxBendB,
  parameter int unsigned MXKEYB       = DefMxKeyB,
  parameter int unsigned MXOFFB       = DefMxOffB,
  parameter int unsigned MINKEYHSME1B = MinKeyHsMe1b,
  parameter int unsigned MAXKEYHSME1B = MaxKeyHsMe1b,
  parameter int unsigned MINKEYHSME1A = MinKeyHsMe1a,
  parameter int unsigned MAXKEYHSME1A = MaxKeyHsMe1a
) (
  input  logic                          clock,
  input  logic                          global_reset,
  clct_gem_slope_corr_lut_if.slave      bus,
  input  logic                          lut_wr,
  input  logic [2+MXLAYB+MXBENDB-1:0]   lut_adr,
  input  logic [MXOFFB-1:0]             lut_wdata,
  output logic [MXOFFB-1:0]             lut_rdata
);
  localparam int unsigned NSlot    = NCLCT * NLAYER;
  localparam int unsigned AdrB     = 2 + MXLAYB + MXBENDB;
  localparam int unsigned LutDepth = 1 << AdrB;

  logic [MXOFFB-1:0] lutMem [LutDepth];

  logic [AdrB-1:0]   offAdr [NSlot];
  logic [MXOFFB-1:0] offRd  [NSlot];

  logic              s1Valid;
  logic              s1ClampEn;
  logic [NCLCT-1:0]  s1Lr;
  logic [NCLCT-1:0]  s1Me1a;
  logic [MXKEYB-1:0] s1Xky  [NCLCT];
  logic [MXOFFB-1:0] s1Off  [NSlot];

  logic [MXKEYB-1:0] keyNxt  [NSlot];
  logic [MXOFFB-1:0] edgeNxt [NSlot];
  logic [NSlot-1:0]  loNxt;
  logic [NSlot-1:0]  hiNxt;

  for (genvar c = 0; c < NCLCT; c++) begin : gClct
    for (genvar l = 0; l < NLAYER; l++) begin : gLayer
      localparam int unsigned S = slotIdx(c, l, NLAYER);

      assign offAdr[S] = AdrB'(packLutAdr(bus.is_me1a[c], bus.even, l,
                                          32'(bus.clct_bend[c*MXBENDB +: MXBENDB]),
                                          MXLAYB, MXBENDB));
      assign offRd[S]  = lutMem[offAdr[S]];

      clct_gem_slope_corr_slot #(
        .MXKEYB       (MXKEYB),
        .MXOFFB       (MXOFFB),
        .MINKEYHSME1B (MINKEYHSME1B),
        .MAXKEYHSME1B (MAXKEYHSME1B),
        .MINKEYHSME1A (MINKEYHSME1A),
        .MAXKEYHSME1A (MAXKEYHSME1A)
      ) uSlot (
        .xky     (s1Xky[c]),
        .off     (s1Off[S]),
        .lr      (s1Lr[c]),
        .me1a    (s1Me1a[c]),
        .clampEn (s1ClampEn),
        .key     (keyNxt[S]),
        .edgeLo  (loNxt[S]),
        .edgeHi  (hiNxt[S]),
        .edgeOff (edgeNxt[S])
      );
    end
  end

  // Readback and stage-1 offset capture both see the LUT before this edge's write.
  always_ff @(posedge clock) begin
    if (global_reset) begin
      for (int i = 0; i < LutDepth; i++) lutMem[i] <= '0;
      lut_rdata <= '0;
    end else begin
      if (lut_wr) lutMem[lut_adr] <= lut_wdata;
      lut_rdata <= lutMem[lut_adr];
    end
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      s1Valid   <= 1'b0;
      s1ClampEn <= 1'b0;
      s1Lr      <= '0;
      s1Me1a    <= '0;
      for (int c = 0; c < NCLCT; c++) s1Xky[c] <= '0;
      for (int s = 0; s < NSlot; s++) s1Off[s] <= '0;
    end else begin
      s1Valid   <= bus.valid_in;
      s1ClampEn <= bus.clamp_en;
      s1Lr      <= bus.clct_lr;
      s1Me1a    <= bus.is_me1a;
      for (int c = 0; c < NCLCT; c++) s1Xky[c] <= bus.clct_xky[c*MXKEYB +: MXKEYB];
      for (int s = 0; s < NSlot; s++) s1Off[s] <= offRd[s];
    end
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      bus.valid_out  <= 1'b0;
      bus.xky_corr   <= '0;
      bus.outedge_lo <= '0;
      bus.outedge_hi <= '0;
      bus.edgeoffset <= '0;
    end else begin
      bus.valid_out  <= s1Valid;
      bus.outedge_lo <= loNxt;
      bus.outedge_hi <= hiNxt;
      for (int s = 0; s < NSlot; s++) begin
        bus.xky_corr[s*MXKEYB +: MXKEYB]   <= keyNxt[s];
        bus.edgeoffset[s*MXOFFB +: MXOFFB] <= edgeNxt[s];
      end
    end
  end

endmodule

// File: tb/tb_clct_gem_slope_corr_lut.sv
// Directed scoreboard bench for clct_gem_slope_corr_lut.
module tb_clct_gem_slope_corr_lut;

  localparam int unsigned KB = 10;
  localparam int unsigned OB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       lutWr;
  logic [6:0] lutAdr;
  logic [7:0] lutWdata;
  logic [7:0] lutRdata;

  clct_gem_slope_corr_lut_if bus ();

  clct_gem_slope_corr_lut dut (
    .clock        (clk),
    .global_reset (rst),
    .bus          (bus),
    .lut_wr       (lutWr),
    .lut_adr      (lutAdr),
    .lut_wdata    (lutWdata),
    .lut_rdata    (lutRdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    slot;
    int    key;
    int    lo;
    int    hi;
    int    eoff;
    int    cyc;
  } exp_t;

  exp_t expQ[$];
  int   nCmp = 0;
  int   nErr = 0;

  task automatic chk(input string nm, input int act, input int req);
    nCmp++;
    if (act != req) begin
      nErr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: pop one expectation per valid_out pulse.
  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) begin
      if (expQ.size() == 0) begin
        nCmp++;
        nErr++;
        $display("FAIL unexpected_valid: got valid_out=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        chk({e.name, "_key"}, int'(bus.xky_corr[e.slot*KB +: KB]), e.key);
        chk({e.name, "_lo"}, int'(bus.outedge_lo[e.slot]), e.lo);
        chk({e.name, "_hi"}, int'(bus.outedge_hi[e.slot]), e.hi);
        chk({e.name, "_eoff"}, int'(bus.edgeoffset[e.slot*OB +: OB]), e.eoff);
        chk({e.name, "_lat"}, cyc, e.cyc);
      end
    end
  end

  task automatic clearIn();
    bus.valid_in  = 1'b0;
    bus.clct_xky  = '0;
    bus.clct_bend = '0;
    bus.clct_lr   = '0;
    bus.is_me1a   = '0;
    bus.even      = 1'b0;
    bus.clamp_en  = 1'b0;
    lutWr         = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      clearIn();
    end
  endtask

  task automatic lutWrite(input int adr, input int data);
    @(posedge clk);
    #1;
    clearIn();
    lutWr    = 1'b1;
    lutAdr   = 7'(adr);
    lutWdata = 8'(data);
  endtask

  task automatic setClct(input int c, input int xky, input int bend, input bit lr,
                         input bit me1a, input bit ev, input bit ce);
    bus.valid_in               = 1'b1;
    bus.clct_xky[c*KB +: KB]   = 10'(xky);
    bus.clct_bend[c*4 +: 4]    = 4'(bend);
    bus.clct_lr[c]             = lr;
    bus.is_me1a[c]             = me1a;
    bus.even                   = ev;
    bus.clamp_en               = ce;
  endtask

  task automatic pushExp(input string nm, input int slot, input int key, input int lo,
                         input int hi, input int eoff);
    exp_t e;
    e.name = nm; e.slot = slot; e.key = key; e.lo = lo; e.hi = hi; e.eoff = eoff;
    e.cyc  = cyc + 2;
    expQ.push_back(e);
  endtask

  task automatic issue(input string nm, input int c, input int xky, input int bend,
                       input bit lr, input bit me1a, input bit ev, input bit ce,
                       input int slot, input int key, input int lo, input int hi,
                       input int eoff);
    @(posedge clk);
    #1;
    clearIn();
    setClct(c, xky, bend, lr, me1a, ev, ce);
    pushExp(nm, slot, key, lo, hi, eoff);
  endtask

  initial begin
    clearIn();
    lutAdr   = '0;
    lutWdata = '0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", int'(bus.valid_out), 0);
    chk("rst_xky", int'(bus.xky_corr), 0);
    chk("rst_edges", int'({bus.outedge_lo, bus.outedge_hi}), 0);
    chk("rst_eoff", int'(bus.edgeoffset), 0);
    chk("rst_rdata", int'(lutRdata), 0);

    lutWrite(7'h05, 20);   // me1b odd l0 bend5
    lutWrite(7'h73, 40);   // me1a even l1 bend3
    lutWrite(7'h07, 255);  // me1b odd l0 bend7
    lutWrite(7'h09, 10);   // me1b odd l0 bend9

    // Back-to-back at full rate.
    issue("t1_sub",     0, 100,  5, 1, 0, 0, 0, 0,   80, 0, 0,   0);
    issue("t2_lo",      0, 15,   5, 1, 0, 0, 0, 0,    0, 1, 0,   5);
    issue("t2_eq",      0, 20,   5, 1, 0, 0, 0, 0,    0, 0, 0,   0);
    issue("t3_hi",      0, 870,  3, 0, 1, 1, 1, 1,  895, 0, 1,  15);
    issue("t3_noclamp", 0, 870,  3, 0, 1, 1, 0, 1,  910, 0, 0,   0);
    issue("t4_lo",      0, 530,  3, 1, 1, 1, 1, 1,  512, 1, 0,  22);
    issue("t5_hi232",   0, 1000, 7, 0, 0, 0, 0, 0, 1023, 0, 1, 232);
    issue("t5_lo255",   0, 0,    7, 1, 0, 0, 0, 0,    0, 1, 0, 255);
    issue("me1b_hi",    0, 500,  5, 0, 0, 0, 1, 0,  511, 0, 1,   9);
    issue("me1b_eq",    0, 491,  5, 0, 0, 0, 1, 0,  511, 0, 0,   0);
    issue("clct1_sub",  1, 300,  5, 1, 0, 0, 0, 2,  280, 0, 0,   0);
    idle(4);

    // Write on the same edge as a sample: old offset and old readback.
    @(posedge clk);
    #1;
    clearIn();
    setClct(0, 100, 9, 0, 0, 0, 0);
    lutWr    = 1'b1;
    lutAdr   = 7'h09;
    lutWdata = 8'd50;
    pushExp("t6_old", 0, 110, 0, 0, 0);
    @(posedge clk);
    #1;
    clearIn();
    chk("t6_rdata_old", int'(lutRdata), 10);
    issue("t6_new", 0, 100, 9, 0, 0, 0, 0, 0, 150, 0, 0, 0);
    idle(4);

    // Reset one cycle after valid_in: transaction must vanish.
    @(posedge clk);
    #1;
    clearIn();
    setClct(0, 100, 5, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    clearIn();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);
    chk("t6r_valid", int'(bus.valid_out), 0);
    chk("t6r_xky", int'(bus.xky_corr), 0);
    chk("t6r_edges", int'({bus.outedge_lo, bus.outedge_hi}), 0);
    chk("t6r_eoff", int'(bus.edgeoffset), 0);
    chk("t6r_rdata", int'(lutRdata), 0);
    chk("t6r_pending", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
